// File: rtl/i2c_target_if.sv
// Bus and user-side signals of the I2C target endpoint.
// The slave modport is the target's view; the master modport is the environment's view.
interface i2c_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_out;
  logic       sda_enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_out, sda_enable, rx_data, rx_valid, tx_req, busy
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_out, sda_enable, rx_data, rx_valid, tx_req, busy
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target with fixed 7-bit address, no clock stretching; open-drain SDA, input-only SCL.
// Optional input glitch filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h2F
) (
  input  logic         clk,
  input  logic         rst,
  i2c_target_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR_RX, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } state_t;

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic       scl, sda, scl_q, sda_q;
  logic [2:0] cnt;
  logic [7:0] sr;
  logic       rw, load;

  // Synchronizers reset to the idle-high bus level so reset release creates no edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_f, sda_f;

  // Filtered level follows only after three consecutive equal synced samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      if (scl_hist == {2{scl_sync[1]}}) scl_f <= scl_sync[1];
      if (sda_hist == {2{sda_sync[1]}}) sda_f <= sda_sync[1];
    end
  end

  assign scl = scl_f;
  assign sda = sda_f;
`else
  assign scl = scl_sync[1];
  assign sda = sda_sync[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  logic       scl_rise, scl_fall, start, stop;
  logic [7:0] shift_in;

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start    = scl & sda_q & ~sda;
  assign stop     = scl & ~sda_q & sda;
  assign shift_in = {sr[6:0], sda};

  assign bus.sda_out = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      sr             <= 8'h00;
      rw             <= 1'b0;
      load           <= 1'b0;
      bus.sda_enable <= 1'b0;
      bus.rx_data    <= 8'h00;
      bus.rx_valid   <= 1'b0;
      bus.tx_req     <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.tx_req   <= 1'b0;
      if (start) begin
        state          <= ADDR_RX;
        cnt            <= 3'd0;
        bus.busy       <= 1'b1;
        bus.sda_enable <= 1'b0;
      end else if (stop) begin
        state          <= IDLE;
        bus.busy       <= 1'b0;
        bus.sda_enable <= 1'b0;
      end else begin
        case (state)
          ADDR_RX: begin
            if (scl_rise) begin
              sr  <= shift_in;
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                rw    <= sda;
                state <= (shift_in[7:1] == ADDR) ? ADDR_ACK : IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bus.sda_enable <= 1'b1;
            end else if (scl_rise) begin
              cnt <= 3'd0;
              if (rw) begin
                bus.tx_req <= 1'b1;
                load       <= 1'b1;
                state      <= READ;
              end else begin
                state <= WRITE;
              end
            end
          end
          WRITE: begin
            if (scl_fall) begin
              bus.sda_enable <= 1'b0;
            end else if (scl_rise) begin
              sr  <= shift_in;
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                bus.rx_data  <= shift_in;
                bus.rx_valid <= 1'b1;
                state        <= WRITE_ACK;
              end
            end
          end
          WRITE_ACK: begin
            if (scl_fall)      bus.sda_enable <= 1'b1;
            else if (scl_rise) state <= WRITE;
          end
          READ: begin
            // sr is pre-shifted so sr[7] always holds the next bit to drive.
            if (scl_fall) begin
              if (load) begin
                sr             <= {bus.tx_data[6:0], 1'b0};
                bus.sda_enable <= ~bus.tx_data[7];
                load           <= 1'b0;
              end else begin
                sr             <= {sr[6:0], 1'b0};
                bus.sda_enable <= ~sr[7];
              end
            end else if (scl_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) state <= READ_ACK;
            end
          end
          READ_ACK: begin
            if (scl_fall) begin
              bus.sda_enable <= 1'b0;
            end else if (scl_rise) begin
              cnt <= 3'd0;
              if (!sda) begin
                bus.tx_req <= 1'b1;
                load       <= 1'b1;
                state      <= READ;
              end else begin
                state <= IGNORE;
              end
            end
          end
          default: bus.sda_enable <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on an open-drain bus model.
module tb_i2c_target;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_ctrl = 1'b1;

  always #5 clk = ~clk;

  i2c_target_if bus ();

  assign bus.scl_in = scl_drv;
  assign bus.sda_in = bus.sda_enable ? (bus.sda_out & sda_ctrl) : sda_ctrl;

  i2c_target #(.ADDR(7'h2F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int rx_cnt = 0, tx_cnt = 0, en_cnt = 0, busy_cnt = 0;
  int n_chk = 0, n_pass = 0;
  logic [7:0] tx_vals [4] = '{8'h3C, 8'hC3, 8'h77, 8'h00};
  int tx_idx = 0;

  always @(posedge clk) begin
    if (bus.rx_valid)   rx_cnt++;
    if (bus.tx_req)     tx_cnt++;
    if (bus.sda_enable) en_cnt++;
    if (bus.busy)       busy_cnt++;
  end

  always @(negedge clk) begin
    if (bus.tx_req) begin
      bus.tx_data = tx_vals[tx_idx];
      tx_idx = (tx_idx + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    cyc(2); sda_ctrl = 1'b1;
    cyc(6); scl_drv = 1'b1;
    cyc(8); sda_ctrl = 1'b0;
    cyc(8); scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(2); sda_ctrl = 1'b0;
    cyc(6); scl_drv = 1'b1;
    cyc(8); sda_ctrl = 1'b1;
    cyc(8);
  endtask

  task automatic write_bit(input logic b, output logic s);
    cyc(2); sda_ctrl = b;
    cyc(6); scl_drv = 1'b1;
    cyc(4); s = bus.sda_in;
    cyc(4); scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) write_bit(v[i], s);
    write_bit(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      write_bit(1'b1, s);
      d = {d[6:0], s};
    end
    write_bit(ack, s);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       a, s;
    logic [7:0] d;
    logic [7:0] pat;
    int rx0, tx0, en0;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    int b0;
`endif

    cyc(3);
    check("rst_sda_enable", bus.sda_enable, 0);
    check("rst_sda_out",    bus.sda_out,    0);
    check("rst_rx_data",    bus.rx_data,    0);
    check("rst_rx_valid",   bus.rx_valid,   0);
    check("rst_tx_req",     bus.tx_req,     0);
    check("rst_busy",       bus.busy,       0);
    rst = 1'b0;
    cyc(4);

    // Addressed write of 0xA5.
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h5E, a); check("wr_addr_ack", a, 0);
    send_byte(8'hA5, a); check("wr_data_ack", a, 0);
    check("wr_rx_data", bus.rx_data, 8'hA5);
    check("wr_rx_pulses", rx_cnt - rx0, 1);
    check("wr_busy", bus.busy, 1);
    i2c_stop();
    check("wr_busy_after_stop", bus.busy, 0);

    // Address 0x30 must be ignored.
    rx0 = rx_cnt; tx0 = tx_cnt; en0 = en_cnt;
    i2c_start();
    send_byte(8'h60, a); check("mm_addr_nack", a, 1);
    send_byte(8'h55, a); check("mm_data_nack", a, 1);
    i2c_stop();
    check("mm_no_drive", en_cnt - en0, 0);
    check("mm_no_rx", rx_cnt - rx0, 0);
    check("mm_no_tx", tx_cnt - tx0, 0);

    // Two-byte read: ACK first byte, NACK second.
    tx0 = tx_cnt;
    i2c_start();
    send_byte(8'h5F, a); check("rd_addr_ack", a, 0);
    recv_byte(d, 1'b0);  check("rd_byte0", d, 8'h3C);
    recv_byte(d, 1'b1);  check("rd_byte1", d, 8'hC3);
    check("rd_tx_pulses", tx_cnt - tx0, 2);
    cyc(4);
    check("rd_released", bus.sda_enable, 0);
    en0 = en_cnt;
    i2c_stop();
    check("rd_no_drive_after_nack", en_cnt - en0, 0);
    check("rd_busy_after_stop", bus.busy, 0);

    // Repeated START in the middle of a write byte, then a read.
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'h5E, a); check("rs_addr_ack", a, 0);
    pat = 8'h11;
    for (int i = 7; i >= 4; i--) write_bit(pat[i], s);
    i2c_start();
    check("rs_partial_no_rx", rx_cnt - rx0, 0);
    send_byte(8'h5F, a); check("rs_read_addr_ack", a, 0);
    recv_byte(d, 1'b1);  check("rs_read_byte", d, 8'h77);
    i2c_stop();
    check("rs_rx_data_kept", bus.rx_data, 8'hA5);
    check("rs_total_no_rx", rx_cnt - rx0, 0);

    // Reset while the target drives the data ACK.
    i2c_start();
    send_byte(8'h5E, a); check("ra_addr_ack", a, 0);
    pat = 8'h3A;
    for (int i = 7; i >= 0; i--) write_bit(pat[i], s);
    cyc(2); sda_ctrl = 1'b1;
    cyc(4);
    check("ra_ack_driven", bus.sda_enable, 1);
    rst = 1'b1;
    #1;
    check("ra_async_release", bus.sda_enable, 0);
    check("ra_busy_cleared", bus.busy, 0);
    cyc(2); rst = 1'b0;
    cyc(2); scl_drv = 1'b1;
    cyc(8); scl_drv = 1'b0;
    en0 = en_cnt; rx0 = rx_cnt;
    send_byte(8'h5E, a); check("ra_no_ack_without_start", a, 1);
    check("ra_no_drive", en_cnt - en0, 0);
    check("ra_no_rx", rx_cnt - rx0, 0);
    check("ra_busy_idle", bus.busy, 0);
    i2c_stop();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // Idle bus: a 2-cycle SDA dip is filtered, a 3-cycle dip is a START.
    cyc(8);
    b0 = busy_cnt;
    sda_ctrl = 1'b0; cyc(2); sda_ctrl = 1'b1;
    cyc(12);
    check("gf_2cyc_suppressed", busy_cnt - b0, 0);
    b0 = busy_cnt;
    sda_ctrl = 1'b0; cyc(3); sda_ctrl = 1'b1;
    cyc(12);
    check("gf_3cyc_start", (busy_cnt - b0) != 0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint, the far end of the bus driven by `i2c_controller`: it listens on SCL/SDA, matches a fixed 7-bit address, and ACKs. Write bytes from the controller go out on a byte-wide strobe interface, and read bytes come from a request/data interface. It sits behind two `SB_IO` tristate pull-up pads in the same way as the controller: SDA is open-drain (drive low or release), and SCL is input-only because the block does no clock stretching.

## Interface
Parameters:
- `ADDR`, 7'h2F, 7-bit target address to match.

Ports:
- `clk`  in  1  system clock (16 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `scl_in`  in  1  SCL pad input, asynchronous.
- `sda_in`  in  1  SDA pad input, asynchronous.
- `sda_out`  out  1  SDA drive value; constant 0.
- `sda_enable`  out  1  1 = pull SDA low, 0 = release.
- `rx_data`  out  8  last byte received in a write transfer.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated.
- `tx_req`  out  1  one-cycle strobe: supply next read byte on `tx_data`.
- `tx_data`  in  8  read byte; sampled as described under Timing.
- `busy`  out  1  1 from START until STOP.

## Operation
- **Input conditioning.** `scl_in` and `sda_in` each pass through 2-flop synchronizers. Edge detection is done on the synchronized values.
- **START.** A synced SDA falling edge while synced SCL = 1 is a START. From any state, including repeated START mid-byte, the block goes to ADDR, clears the bit counter and sets `busy` = 1.
- **STOP.** A synced SDA rising edge while SCL = 1 is a STOP. From any state the block goes to IDLE, releases SDA and sets `busy` = 0.
- **Bit handling.** SDA is sampled on the SCL rising edge. `sda_enable` changes only on the SCL falling edge. Bytes are MSB first.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. If bits[7:1] == `ADDR`, go to ADDR_ACK; otherwise go to IGNORE.
  - ADDR_ACK: drive SDA low for the 9th bit. Then go to WRITE if R/W = 0, or to READ if R/W = 1.
  - WRITE: shift in 8 bits, then go to WRITE_ACK. Every write byte is always ACKed.
  - WRITE_ACK: drive the ACK low, then return to WRITE.
  - READ: drive 8 bits from the tx shift register. Releasing SDA represents a 1 bit.
  - READ_ACK: release SDA and sample the controller's bit. ACK (0) goes to READ with a new byte. NACK (1) goes to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- **Address match.** Only the exact 7-bit match on `ADDR` is accepted. There is no general call and no 10-bit addressing.
- **Bus constraint.** SCL high and low phases must each be at least 4 `clk` cycles; 400 kHz at 16 MHz meets this.

## Timing
- **Reset values:** `sda_enable` = 0, `sda_out` = 0, `rx_data` = 0, `rx_valid` = 0, `tx_req` = 0, `busy` = 0, state = IDLE.
- **Input latency.** The synchronizer adds 2 cycles from pad to internal edge detection.
- **`rx_valid`.** It is high for exactly one cycle, 1 cycle after the internal SCL rising edge that samples bit 0 of a write byte. `rx_data` holds its value until the next write byte completes.
- **`tx_req`.** It pulses 1 cycle after the SCL rising edge of the 9th bit in ADDR_ACK with R/W = 1, and 1 cycle after a sampled master ACK in READ_ACK.
- **`tx_data` sampling.** `tx_data` is captured into the shift register on the next internal SCL falling edge. That edge also drives the MSB.
- **Holding `tx_data`.** The user must hold `tx_data` stable from the `tx_req` pulse until that falling edge, which is at least 4 cycles later.
- **ACK release.** `sda_enable` for an ACK deasserts on the SCL falling edge that ends the 9th bit.
- **Reset mid-transfer.** SDA is released immediately (asynchronous). After reset the block ignores the bus until the next START.
- **Simultaneous events.** A START or STOP in the same cycle as a data SCL edge takes priority over that edge.

## Configuration
- **With `I2C_TARGET_GLITCH_FILTER_EN` defined:**
  - Each synced line passes a filter after the synchronizer: the filtered value changes only after 3 consecutive equal samples.
  - Total input latency is 5 cycles, and pulses of 2 cycles or shorter are suppressed.
- **Without it:** there is no filter and input latency is 2 cycles.
- All output timing above is stated relative to the internal (post-filter) edges.

## Test plan
- **Addressed write.** Controller writes address 0x2F, W, then 0xA5 → ACK low on both 9th bits; `rx_data` = 0xA5 with exactly one `rx_valid` pulse; `busy` falls after STOP.
- **Address mismatch.** Controller writes address 0x30 → `sda_enable` stays 0 for the whole transfer (NACK), with no `rx_valid` and no `tx_req`.
- **Two-byte read.** Controller reads from 0x2F; bench returns 0x3C on the first `tx_req` and 0xC3 on the second; controller ACKs byte 1 and NACKs byte 2 → SDA carries 0x3C then 0xC3; exactly 2 `tx_req` pulses; SDA released after the NACK.
- **Repeated START.** Write 0x11, then repeated START mid-byte, then read → state returns to ADDR; the partial byte produces no `rx_valid`; the read completes correctly.
- **Reset mid-ACK.** Assert `rst` while the block drives an ACK → `sda_enable` = 0 in the same cycle; the next byte without a fresh START is ignored.
- **Glitch filter.** With `I2C_TARGET_GLITCH_FILTER_EN`, inject a 2-cycle SDA low glitch while SCL is high → no START detected; a 3-cycle or longer SDA low pulse is detected as a START.
